// File: rtl/ex_stage_mc_if.sv
// ID/EX-side request bus and EX/MEM-side result bus of the multi-cycle execute stage.
interface ex_stage_mc_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 6,
  parameter int RA_W   = 3
);
  logic              in_valid;
  logic              flush;
  logic [3:0]        alu_op;
  logic              alu_src;
  logic [DATA_W-1:0] reg1_data;
  logic [DATA_W-1:0] reg2_data;
  logic [IMM_W-1:0]  immediate;
  logic [RA_W-1:0]   rd;
  logic [RA_W-1:0]   rt;
  logic [1:0]        reg_dst;
  logic              reg_write;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic [DATA_W-1:0] mem_forward_data;
  logic [DATA_W-1:0] wb_forward_data;
  logic              stall;
  logic              exm_valid;
  logic [DATA_W-1:0] exm_result;
  logic              exm_zero;
  logic [RA_W-1:0]   exm_write_reg;
  logic              exm_reg_write;

  modport master (
    output in_valid, flush, alu_op, alu_src, reg1_data, reg2_data, immediate,
           rd, rt, reg_dst, reg_write, forward_a, forward_b,
           mem_forward_data, wb_forward_data,
    input  stall, exm_valid, exm_result, exm_zero, exm_write_reg, exm_reg_write
  );

  modport slave (
    input  in_valid, flush, alu_op, alu_src, reg1_data, reg2_data, immediate,
           rd, rt, reg_dst, reg_write, forward_a, forward_b,
           mem_forward_data, wb_forward_data,
    output stall, exm_valid, exm_result, exm_zero, exm_write_reg, exm_reg_write
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Execute stage with registered EX/MEM output and an iterative shift-add multiplier /
// restoring divider that holds the pipeline while it runs.
module ex_stage_mc #(
  parameter int DATA_W   = 16,
  parameter int IMM_W    = 6,
  parameter int RA_W     = 3,
  parameter int LINK_REG = 7
) (
  input logic          clk,
  input logic          rst_n,
  ex_stage_mc_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_DIV = 4'd11;

  localparam int                 CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r, state_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [IMM_W-1:0]  imm_s;
  logic [DATA_W-1:0] imm_ext_s, op_a_s, fwd_b_s, op_b_s, alu_res_s;
  logic [CNT_W-1:0]  sh_s;
  logic              slt_s, mc_op_s, stall_s;
  logic [RA_W-1:0]   wreg_s;

  // a_r: multiplicand (MUL) or dividend/quotient (DIV); b_r: multiplier or divisor;
  // acc_r: partial product or partial remainder.
  logic [DATA_W-1:0] a_r, b_r, acc_r, a_n, b_n, acc_n;
  logic              div_r, div_n, mc_rw_r, mc_rw_n;
  logic [RA_W-1:0]   mc_wreg_r, mc_wreg_n;
  logic [DATA_W:0]   rem_sh_s;
  logic              div_ge_s;
  logic [DATA_W-1:0] div_rem_s, div_quo_s, mul_acc_s, mc_res_s;

  logic              exm_valid_r, exm_valid_n, exm_zero_r, exm_zero_n, exm_rw_r, exm_rw_n;
  logic [DATA_W-1:0] exm_result_r, exm_result_n;
  logic [RA_W-1:0]   exm_wreg_r, exm_wreg_n;

  assign imm_s     = bus.immediate;
  assign imm_ext_s = DATA_W'($signed(imm_s));
  assign sh_s      = op_b_s[CNT_W-1:0];
  assign slt_s     = $signed(op_a_s) < $signed(op_b_s);
  assign mc_op_s   = (bus.alu_op == ALU_MUL) || (bus.alu_op == ALU_DIV);

  // Forwarding muxes, immediate select and destination select.
  always_comb begin
    case (bus.forward_a)
      2'b01:   op_a_s = bus.mem_forward_data;
      2'b10:   op_a_s = bus.wb_forward_data;
      default: op_a_s = bus.reg1_data;
    endcase
    case (bus.forward_b)
      2'b01:   fwd_b_s = bus.mem_forward_data;
      2'b10:   fwd_b_s = bus.wb_forward_data;
      default: fwd_b_s = bus.reg2_data;
    endcase
    if (bus.alu_src) begin
      op_b_s = imm_ext_s;
    end else begin
      op_b_s = fwd_b_s;
    end
    case (bus.reg_dst)
      2'b01:   wreg_s = bus.rt;
      2'b10:   wreg_s = RA_W'(LINK_REG);
      default: wreg_s = bus.rd;
    endcase
  end

  // Single-cycle ALU.
  always_comb begin
    alu_res_s = '0;
    case (bus.alu_op)
      ALU_ADD: alu_res_s = op_a_s + op_b_s;
      ALU_SUB: alu_res_s = op_a_s - op_b_s;
      ALU_AND: alu_res_s = op_a_s & op_b_s;
      ALU_OR:  alu_res_s = op_a_s | op_b_s;
      ALU_XOR: alu_res_s = op_a_s ^ op_b_s;
      ALU_NOR: alu_res_s = ~(op_a_s | op_b_s);
      ALU_SLT: alu_res_s = {{(DATA_W-1){1'b0}}, slt_s};
      ALU_SLL: alu_res_s = op_a_s << sh_s;
      ALU_SRL: alu_res_s = op_a_s >> sh_s;
      ALU_SRA: alu_res_s = DATA_W'($signed(op_a_s) >>> sh_s);
      default: alu_res_s = '0;
    endcase
  end

  // One multiply or divide iteration; a zero divisor always compares ">=" so the quotient fills with ones.
  always_comb begin
    rem_sh_s  = {acc_r, a_r[DATA_W-1]};
    div_ge_s  = rem_sh_s >= {1'b0, b_r};
    div_quo_s = {a_r[DATA_W-2:0], div_ge_s};
    if (div_ge_s) begin
      div_rem_s = rem_sh_s[DATA_W-1:0] - b_r;
    end else begin
      div_rem_s = rem_sh_s[DATA_W-1:0];
    end
    if (b_r[0]) begin
      mul_acc_s = acc_r + a_r;
    end else begin
      mul_acc_s = acc_r;
    end
    if (div_r) begin
      mc_res_s = div_quo_s;
    end else begin
      mc_res_s = mul_acc_s;
    end
  end

  // Next-state, stall and EX/MEM load decisions.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    a_n          = a_r;
    b_n          = b_r;
    acc_n        = acc_r;
    div_n        = div_r;
    mc_rw_n      = mc_rw_r;
    mc_wreg_n    = mc_wreg_r;
    exm_valid_n  = 1'b0;
    exm_rw_n     = 1'b0;
    exm_result_n = exm_result_r;
    exm_zero_n   = exm_zero_r;
    exm_wreg_n   = exm_wreg_r;
    stall_s      = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state_r == IDLE) begin
      if (bus.in_valid && mc_op_s) begin
        stall_s   = 1'b1;
        state_n   = BUSY;
        cnt_n     = '0;
        a_n       = op_a_s;
        b_n       = op_b_s;
        acc_n     = '0;
        div_n     = (bus.alu_op == ALU_DIV);
        mc_rw_n   = bus.reg_write;
        mc_wreg_n = wreg_s;
      end else if (bus.in_valid) begin
        exm_valid_n  = 1'b1;
        exm_rw_n     = bus.reg_write;
        exm_result_n = alu_res_s;
        exm_zero_n   = (alu_res_s == '0);
        exm_wreg_n   = wreg_s;
      end else begin
        state_n = IDLE;
      end
    end else begin
      cnt_n = cnt_r + CNT_W'(1);
      if (div_r) begin
        a_n   = div_quo_s;
        acc_n = div_rem_s;
      end else begin
        a_n   = {a_r[DATA_W-2:0], 1'b0};
        b_n   = {1'b0, b_r[DATA_W-1:1]};
        acc_n = mul_acc_s;
      end
      if (cnt_r == CNT_LAST) begin
        state_n      = IDLE;
        cnt_n        = '0;
        exm_valid_n  = 1'b1;
        exm_rw_n     = mc_rw_r;
        exm_result_n = mc_res_s;
        exm_zero_n   = (mc_res_s == '0);
        exm_wreg_n   = mc_wreg_r;
      end else begin
        stall_s = 1'b1;
      end
    end
  end

  // FSM state and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Latched multi-cycle operands/accumulator and the EX/MEM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r          <= '0;
      b_r          <= '0;
      acc_r        <= '0;
      div_r        <= 1'b0;
      mc_rw_r      <= 1'b0;
      mc_wreg_r    <= '0;
      exm_valid_r  <= 1'b0;
      exm_rw_r     <= 1'b0;
      exm_result_r <= '0;
      exm_zero_r   <= 1'b0;
      exm_wreg_r   <= '0;
    end else begin
      a_r          <= a_n;
      b_r          <= b_n;
      acc_r        <= acc_n;
      div_r        <= div_n;
      mc_rw_r      <= mc_rw_n;
      mc_wreg_r    <= mc_wreg_n;
      exm_valid_r  <= exm_valid_n;
      exm_rw_r     <= exm_rw_n;
      exm_result_r <= exm_result_n;
      exm_zero_r   <= exm_zero_n;
      exm_wreg_r   <= exm_wreg_n;
    end
  end

  assign bus.stall         = rst_n & stall_s;
  assign bus.exm_valid     = exm_valid_r;
  assign bus.exm_result    = exm_result_r;
  assign bus.exm_zero      = exm_zero_r;
  assign bus.exm_write_reg = exm_wreg_r;
  assign bus.exm_reg_write = exm_rw_r;
endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU vector table on a 16-bit instance, plus multi-cycle,
// flush and reset sequences on 16-bit and 8-bit instances.
module tb_ex_stage_mc;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_MUL = 4'd10;
  localparam logic [3:0] ALU_DIV = 4'd11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        use8, in_valid, flush, alu_src, reg_write;
  logic [3:0]  alu_op;
  logic [15:0] reg1, reg2, mem_fwd, wb_fwd;
  logic [5:0]  imm;
  logic [2:0]  rd, rt;
  logic [1:0]  reg_dst, fwd_a, fwd_b;

  ex_stage_mc_if #(.DATA_W(16), .IMM_W(6), .RA_W(3)) b16 ();
  ex_stage_mc_if #(.DATA_W(8),  .IMM_W(6), .RA_W(3)) b8 ();

  ex_stage_mc #(.DATA_W(16), .IMM_W(6), .RA_W(3), .LINK_REG(7)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  ex_stage_mc #(.DATA_W(8),  .IMM_W(6), .RA_W(3), .LINK_REG(7)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  assign b16.in_valid = in_valid & ~use8;     assign b8.in_valid = in_valid & use8;
  assign b16.flush = flush;                   assign b8.flush = flush;
  assign b16.alu_op = alu_op;                 assign b8.alu_op = alu_op;
  assign b16.alu_src = alu_src;               assign b8.alu_src = alu_src;
  assign b16.reg1_data = reg1;                assign b8.reg1_data = reg1[7:0];
  assign b16.reg2_data = reg2;                assign b8.reg2_data = reg2[7:0];
  assign b16.immediate = imm;                 assign b8.immediate = imm;
  assign b16.rd = rd;                         assign b8.rd = rd;
  assign b16.rt = rt;                         assign b8.rt = rt;
  assign b16.reg_dst = reg_dst;               assign b8.reg_dst = reg_dst;
  assign b16.reg_write = reg_write;           assign b8.reg_write = reg_write;
  assign b16.forward_a = fwd_a;               assign b8.forward_a = fwd_a;
  assign b16.forward_b = fwd_b;               assign b8.forward_b = fwd_b;
  assign b16.mem_forward_data = mem_fwd;      assign b8.mem_forward_data = mem_fwd[7:0];
  assign b16.wb_forward_data = wb_fwd;        assign b8.wb_forward_data = wb_fwd[7:0];

  logic        stall_s, vld_s, zero_s, rw_s;
  logic [15:0] res_s;
  logic [2:0]  wreg_s;
  assign stall_s = use8 ? b8.stall : b16.stall;
  assign vld_s   = use8 ? b8.exm_valid : b16.exm_valid;
  assign zero_s  = use8 ? b8.exm_zero : b16.exm_zero;
  assign rw_s    = use8 ? b8.exm_reg_write : b16.exm_reg_write;
  assign res_s   = use8 ? {8'h00, b8.exm_result} : b16.exm_result;
  assign wreg_s  = use8 ? b8.exm_write_reg : b16.exm_write_reg;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [1:0]  fa, fb;
    logic [15:0] r1, r2, mf, wf;
    logic [5:0]  imm;
    logic [1:0]  rdst;
    logic        rw;
    logic [15:0] exp_res;
    logic        exp_zero;
    logic [2:0]  exp_wreg;
  } vec_t;

  vec_t vecs [13];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid  = 1'b1;
    flush     = 1'b0;
    alu_op    = op;
    alu_src   = 1'b0;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    reg1      = a;
    reg2      = b;
    rd        = 3'd5;
    reg_dst   = 2'b00;
    reg_write = 1'b1;
  endtask

  // Runs one MUL/DIV, scrambling every input bus while busy; exits in the cycle the result is visible.
  task automatic run_mc(input string name, input logic w8, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input int exp_stall);
    int n;
    int bad;
    use8 = w8;
    present(op, a, b);
    #1;
    n   = 0;
    bad = 0;
    while (stall_s && n < 64) begin
      n++;
      tick();
      if (vld_s !== 1'b0) bad++;
      alu_op  = ALU_ADD;
      reg1    = ~a;
      reg2    = 16'h5A5A;
      mem_fwd = 16'h1357;
      wb_fwd  = 16'h2468;
      fwd_a   = 2'b01;
      fwd_b   = 2'b10;
      rd      = 3'd1;
      #1;
    end
    in_valid = 1'b0;
    chk({name, " stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({name, " valid_low_while_busy"}, 32'(bad), 32'd0);
    tick();
    chk({name, " valid"}, 32'(vld_s), 32'd1);
    chk({name, " result"}, 32'(res_s), 32'(exp));
    chk({name, " write_reg"}, 32'(wreg_s), 32'd5);
    chk({name, " reg_write"}, 32'(rw_s), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op       src   fa     fb     r1        r2        mf        wf        imm    rdst   rw    res       z     wreg
    vecs[0]  = '{ALU_ADD, 1'b0, 2'b01, 2'b00, 16'h1111, 16'h0010, 16'h00A0, 16'h0000, 6'h00, 2'b00, 1'b1, 16'h00B0, 1'b0, 3'd2};
    vecs[1]  = '{ALU_ADD, 1'b1, 2'b00, 2'b00, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 6'h3F, 2'b01, 1'b1, 16'h0002, 1'b0, 3'd3};
    vecs[2]  = '{ALU_SUB, 1'b0, 2'b00, 2'b00, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 6'h00, 2'b10, 1'b1, 16'h0000, 1'b1, 3'd7};
    vecs[3]  = '{ALU_AND, 1'b0, 2'b00, 2'b00, 16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 6'h00, 2'b11, 1'b0, 16'hF000, 1'b0, 3'd2};
    vecs[4]  = '{ALU_OR,  1'b0, 2'b00, 2'b10, 16'h00F0, 16'h1234, 16'h0000, 16'h000F, 6'h00, 2'b00, 1'b1, 16'h00FF, 1'b0, 3'd2};
    vecs[5]  = '{ALU_XOR, 1'b0, 2'b11, 2'b00, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h0000, 6'h00, 2'b00, 1'b1, 16'h5555, 1'b0, 3'd2};
    vecs[6]  = '{ALU_SLT, 1'b0, 2'b00, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 6'h00, 2'b00, 1'b1, 16'h0001, 1'b0, 3'd2};
    vecs[7]  = '{ALU_SLL, 1'b1, 2'b00, 2'b00, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 6'h04, 2'b00, 1'b1, 16'h0010, 1'b0, 3'd2};
    vecs[8]  = '{ALU_SRA, 1'b1, 2'b00, 2'b00, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 6'h03, 2'b00, 1'b1, 16'hF000, 1'b0, 3'd2};
    vecs[9]  = '{ALU_SRL, 1'b1, 2'b00, 2'b00, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 6'h03, 2'b00, 1'b1, 16'h1000, 1'b0, 3'd2};
    vecs[10] = '{ALU_NOR, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'h00, 2'b00, 1'b1, 16'hFFFF, 1'b0, 3'd2};
    vecs[11] = '{ALU_SUB, 1'b1, 2'b00, 2'b01, 16'h0000, 16'h0000, 16'h7777, 16'h0000, 6'h20, 2'b00, 1'b1, 16'h0020, 1'b0, 3'd2};
    vecs[12] = '{ALU_ADD, 1'b0, 2'b10, 2'b01, 16'h0000, 16'h0000, 16'h0023, 16'h0100, 6'h00, 2'b00, 1'b1, 16'h0123, 1'b0, 3'd2};

    use8 = 1'b0;
    rst_n = 1'b0;
    present(ALU_MUL, 16'h0003, 16'h0004);
    mem_fwd = 16'h0000;
    wb_fwd  = 16'h0000;
    imm     = 6'h00;
    rt      = 3'd3;
    #12;
    chk("reset stall", 32'(stall_s), 32'd0);
    chk("reset valid", 32'(vld_s), 32'd0);
    chk("reset result", 32'(res_s), 32'd0);
    chk("reset zero", 32'(zero_s), 32'd0);
    chk("reset write_reg", 32'(wreg_s), 32'd0);
    chk("reset reg_write", 32'(rw_s), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      in_valid  = 1'b1;
      flush     = 1'b0;
      alu_op    = vecs[i].op;
      alu_src   = vecs[i].src;
      fwd_a     = vecs[i].fa;
      fwd_b     = vecs[i].fb;
      reg1      = vecs[i].r1;
      reg2      = vecs[i].r2;
      mem_fwd   = vecs[i].mf;
      wb_fwd    = vecs[i].wf;
      imm       = vecs[i].imm;
      rd        = 3'd2;
      rt        = 3'd3;
      reg_dst   = vecs[i].rdst;
      reg_write = vecs[i].rw;
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall_s), 32'd0);
      tick();
      chk($sformatf("vec%0d valid", i), 32'(vld_s), 32'd1);
      chk($sformatf("vec%0d result", i), 32'(res_s), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d zero", i), 32'(zero_s), 32'(vecs[i].exp_zero));
      chk($sformatf("vec%0d write_reg", i), 32'(wreg_s), 32'(vecs[i].exp_wreg));
      chk($sformatf("vec%0d reg_write", i), 32'(rw_s), 32'(vecs[i].rw));
    end
    in_valid = 1'b0;
    tick();

    run_mc("mul16_a", 1'b0, ALU_MUL, 16'h0123, 16'h0010, 16'h1230, 16);
    run_mc("mul16_ovf", 1'b0, ALU_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16);
    run_mc("div16_a", 1'b0, ALU_DIV, 16'h0064, 16'h0007, 16'h000E, 16);
    run_mc("div16_zero", 1'b0, ALU_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16);
    run_mc("div8_a", 1'b1, ALU_DIV, 16'h0064, 16'h0007, 16'h000E, 8);
    run_mc("div8_b", 1'b1, ALU_DIV, 16'h00FF, 16'h0010, 16'h000F, 8);
    run_mc("div8_zero", 1'b1, ALU_DIV, 16'h0055, 16'h0000, 16'h00FF, 8);
    run_mc("mul8_a", 1'b1, ALU_MUL, 16'h0013, 16'h0011, 16'h0043, 8);
    use8 = 1'b0;

    // Flush in BUSY cycle 5 abandons the multiply and returns to IDLE.
    present(ALU_MUL, 16'h0003, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b0;
    end
    flush = 1'b1;
    #1;
    chk("flush_busy stall", 32'(stall_s), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_busy valid", 32'(vld_s), 32'd0);
    chk("flush_busy reg_write", 32'(rw_s), 32'd0);
    present(ALU_ADD, 16'h0001, 16'h0001);
    #1;
    chk("flush_busy idle_stall", 32'(stall_s), 32'd0);
    tick();
    chk("flush_busy idle_valid", 32'(vld_s), 32'd1);
    chk("flush_busy idle_result", 32'(res_s), 32'h0002);

    // Flush beats accept of a multi-cycle op.
    present(ALU_MUL, 16'h0007, 16'h0007);
    flush = 1'b1;
    #1;
    chk("flush_accept stall", 32'(stall_s), 32'd0);
    tick();
    chk("flush_accept valid", 32'(vld_s), 32'd0);
    present(ALU_ADD, 16'h0004, 16'h0004);
    #1;
    chk("flush_accept idle_stall", 32'(stall_s), 32'd0);
    tick();
    chk("flush_accept idle_valid", 32'(vld_s), 32'd1);
    chk("flush_accept idle_result", 32'(res_s), 32'h0008);

    present(ALU_ADD, 16'h0009, 16'h0009);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_single valid", 32'(vld_s), 32'd0);
    chk("flush_single reg_write", 32'(rw_s), 32'd0);

    // Reset in the middle of a divide, then accept immediately after release.
    present(ALU_DIV, 16'h0064, 16'h0007);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid stall", 32'(stall_s), 32'd0);
    chk("rst_mid valid", 32'(vld_s), 32'd0);
    chk("rst_mid result", 32'(res_s), 32'd0);
    chk("rst_mid zero", 32'(zero_s), 32'd0);
    chk("rst_mid write_reg", 32'(wreg_s), 32'd0);
    chk("rst_mid reg_write", 32'(rw_s), 32'd0);
    tick();
    rst_n = 1'b1;
    present(ALU_ADD, 16'h0030, 16'h0005);
    #1;
    chk("rst_release stall", 32'(stall_s), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("rst_release valid", 32'(vld_s), 32'd1);
    chk("rst_release result", 32'(res_s), 32'h0035);
    chk("rst_release write_reg", 32'(wreg_s), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
